// File: rtl/path_seq_pkg.sv
// Shared types and helpers for the path query batch sequencer.
// Holds the FSM state encoding, default geometry and node-id extraction.
package path_seq_pkg;

   localparam int DEF_NODE_W       = 5;
   localparam int DEF_N_PATH_WORDS = 9;
   localparam int LIST_MAX_W       = 1024;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      CAPTURE = 3'd3,
      NEXT    = 3'd4,
      FINISH  = 3'd5
   } state_t;

   function automatic logic [31:0] node_slice(input logic [LIST_MAX_W-1:0] list,
                                              input int unsigned           idx,
                                              input int unsigned           w);
      logic [LIST_MAX_W-1:0] shifted;
      shifted = list >> (idx * w);
      return shifted[31:0] & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/path_result_store.sv
// Per-query path word register file: one write port, one registered read port,
// synchronous clear; out-of-range reads return zero.
module path_result_store
   import path_seq_pkg::*;
#(
   parameter int N_QUERIES    = 4,
   parameter int N_PATH_WORDS = DEF_N_PATH_WORDS,
   parameter int QW           = 2,
   parameter int WW           = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   input  logic [QW-1:0] wr_q,
   input  logic [WW-1:0] wr_w,
   input  logic [31:0]   wr_data,
   input  logic [QW-1:0] rd_q,
   input  logic [WW-1:0] rd_w,
   output logic [31:0]   rd_data
);

   logic [31:0] mem_r [N_QUERIES][N_PATH_WORDS];
   logic [31:0] rd_data_r;

   // Storage array: cleared on reset or on a new batch, written one word at a time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int q = 0; q < N_QUERIES; q++)
            for (int w = 0; w < N_PATH_WORDS; w++)
               mem_r[q][w] <= 32'd0;
      end else if (clr) begin
         for (int q = 0; q < N_QUERIES; q++)
            for (int w = 0; w < N_PATH_WORDS; w++)
               mem_r[q][w] <= 32'd0;
      end else if (we) begin
         mem_r[wr_q][wr_w] <= wr_data;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= 32'd0;
      end else if ((32'(rd_q) < 32'(N_QUERIES)) && (32'(rd_w) < 32'(N_PATH_WORDS))) begin
         rd_data_r <= mem_r[rd_q][rd_w];
      end else begin
         rd_data_r <= 32'd0;
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/path_query_sequencer.sv
// Batch controller for the path-planner CPU: runs up to N_QUERIES (SP, EP) pairs,
// each with a reset pulse, a bounded run and capture of the exported path words.
module path_query_sequencer
   import path_seq_pkg::*;
#(
   parameter int NODE_W       = DEF_NODE_W,
   parameter int N_PATH_WORDS = DEF_N_PATH_WORDS,
   parameter int N_QUERIES    = 4,
   parameter int RST_CYC      = 4,
   parameter int TIMEOUT_CYC  = 1000000
) (
   input  logic                              clk_50M,
   input  logic                              reset,
   input  logic                              start,
   input  logic [$clog2(N_QUERIES+1)-1:0]    num_q,
   input  logic [N_QUERIES*NODE_W-1:0]       sp_list,
   input  logic [N_QUERIES*NODE_W-1:0]       ep_list,
   output logic                              cpu_rst,
   output logic [NODE_W-1:0]                 cpu_SP,
   output logic [NODE_W-1:0]                 cpu_EP,
   input  logic                              cpu_path_found,
   input  logic [N_PATH_WORDS*32-1:0]        cpu_path,
   output logic                              busy,
   output logic                              done,
   output logic [N_QUERIES-1:0]              q_ok,
   output logic [N_QUERIES-1:0]              q_timeout,
   input  logic [$clog2(N_QUERIES)-1:0]      rd_q,
   input  logic [$clog2(N_PATH_WORDS)-1:0]   rd_w,
   output logic [31:0]                       rd_data
);

   localparam int QN_W   = $clog2(N_QUERIES + 1);
   localparam int QW     = $clog2(N_QUERIES);
   localparam int QI_W   = QW + 1;
   localparam int WW     = $clog2(N_PATH_WORDS);
   localparam int TO_W   = $clog2(TIMEOUT_CYC);
   localparam int RC_W   = $clog2(RST_CYC + 1);
   localparam int LIST_W = N_QUERIES * NODE_W;

   state_t                state_r, state_s;
   logic [QN_W-1:0]       num_q_r, num_q_clamp_s;
   logic [LIST_W-1:0]     sp_list_r, ep_list_r;
   logic [QI_W-1:0]       qi_r, qi_s, qi_inc_s;
   logic [QW-1:0]         qi_idx_s;
   logic [RC_W-1:0]       rc_r, rc_s;
   logic [TO_W-1:0]       to_r, to_s;
   logic [WW-1:0]         wi_r, wi_s;
   logic                  pf_meta_r, pf_sync_r, pf_prev_r, found_s;
   logic [N_QUERIES-1:0]  q_ok_r, q_ok_s, q_to_r, q_to_s;
   logic                  busy_r, busy_s, done_r, done_s, cpu_rst_r, cpu_rst_s;
   logic [NODE_W-1:0]     cpu_sp_r, cpu_sp_s, cpu_ep_r, cpu_ep_s;
   logic                  latch_s, st_clr_s, st_we_s;
   logic [31:0]           st_wdata_s;

   assign num_q_clamp_s = (num_q > QN_W'(N_QUERIES)) ? QN_W'(N_QUERIES) : num_q;
   assign qi_inc_s      = qi_r + QI_W'(1);
   assign qi_idx_s      = qi_r[QW-1:0];
   assign found_s       = pf_sync_r & pf_prev_r;
   assign st_wdata_s    = cpu_path[32*wi_r +: 32];

   // Next-state, counter and output-register logic.
   always_comb begin
      state_s  = state_r;
      qi_s     = qi_r;
      rc_s     = rc_r;
      to_s     = to_r;
      wi_s     = wi_r;
      q_ok_s   = q_ok_r;
      q_to_s   = q_to_r;
      cpu_sp_s = cpu_sp_r;
      cpu_ep_s = cpu_ep_r;
      latch_s  = 1'b0;
      st_clr_s = 1'b0;
      st_we_s  = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && (num_q != QN_W'(0))) begin
               latch_s  = 1'b1;
               st_clr_s = 1'b1;
               q_ok_s   = {N_QUERIES{1'b0}};
               q_to_s   = {N_QUERIES{1'b0}};
               qi_s     = {QI_W{1'b0}};
               rc_s     = {RC_W{1'b0}};
               cpu_sp_s = NODE_W'(node_slice(LIST_MAX_W'(sp_list), 32'd0, NODE_W));
               cpu_ep_s = NODE_W'(node_slice(LIST_MAX_W'(ep_list), 32'd0, NODE_W));
               state_s  = LOAD;
            end else if (start) begin
               done_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (rc_r == RC_W'(RST_CYC - 1)) begin
               to_s    = {TO_W{1'b0}};
               state_s = RUN;
            end else begin
               rc_s = rc_r + RC_W'(1);
            end
         end
         RUN: begin
            // A found and an expiring timeout in the same cycle resolve as found.
            if (found_s) begin
               wi_s    = {WW{1'b0}};
               state_s = CAPTURE;
            end else if (to_r == TO_W'(TIMEOUT_CYC - 1)) begin
               q_to_s[qi_idx_s] = 1'b1;
               state_s          = NEXT;
            end else begin
               to_s = (to_r == {TO_W{1'b1}}) ? to_r : to_r + TO_W'(1);
            end
         end
         CAPTURE: begin
            st_we_s = 1'b1;
            if (wi_r == WW'(N_PATH_WORDS - 1)) begin
               q_ok_s[qi_idx_s] = 1'b1;
               state_s          = NEXT;
            end else begin
               wi_s = wi_r + WW'(1);
            end
         end
         NEXT: begin
            qi_s = qi_inc_s;
            if (qi_inc_s == QI_W'(num_q_r)) begin
               done_s  = 1'b1;
               state_s = FINISH;
            end else begin
               rc_s     = {RC_W{1'b0}};
               cpu_sp_s = NODE_W'(node_slice(LIST_MAX_W'(sp_list_r), 32'(qi_inc_s), NODE_W));
               cpu_ep_s = NODE_W'(node_slice(LIST_MAX_W'(ep_list_r), 32'(qi_inc_s), NODE_W));
               state_s  = LOAD;
            end
         end
         FINISH: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s    = (state_s != IDLE);
      cpu_rst_s = !((state_s == RUN) || (state_s == CAPTURE));
   end

   // FSM state, batch context and registered outputs.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         num_q_r   <= {QN_W{1'b0}};
         sp_list_r <= {LIST_W{1'b0}};
         ep_list_r <= {LIST_W{1'b0}};
         qi_r      <= {QI_W{1'b0}};
         rc_r      <= {RC_W{1'b0}};
         to_r      <= {TO_W{1'b0}};
         wi_r      <= {WW{1'b0}};
         q_ok_r    <= {N_QUERIES{1'b0}};
         q_to_r    <= {N_QUERIES{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cpu_rst_r <= 1'b1;
         cpu_sp_r  <= {NODE_W{1'b0}};
         cpu_ep_r  <= {NODE_W{1'b0}};
      end else begin
         state_r   <= state_s;
         qi_r      <= qi_s;
         rc_r      <= rc_s;
         to_r      <= to_s;
         wi_r      <= wi_s;
         q_ok_r    <= q_ok_s;
         q_to_r    <= q_to_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         cpu_rst_r <= cpu_rst_s;
         cpu_sp_r  <= cpu_sp_s;
         cpu_ep_r  <= cpu_ep_s;
         if (latch_s) begin
            num_q_r   <= num_q_clamp_s;
            sp_list_r <= sp_list;
            ep_list_r <= ep_list;
         end
      end
   end

   // path_found synchroniser plus one history flop for the two-cycle filter.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         pf_meta_r <= 1'b0;
         pf_sync_r <= 1'b0;
         pf_prev_r <= 1'b0;
      end else begin
         pf_meta_r <= cpu_path_found;
         pf_sync_r <= pf_meta_r;
         pf_prev_r <= pf_sync_r;
      end
   end

   path_result_store #(
      .N_QUERIES    (N_QUERIES),
      .N_PATH_WORDS (N_PATH_WORDS),
      .QW           (QW),
      .WW           (WW)
   ) u_store (
      .clk     (clk_50M),
      .rst     (reset),
      .clr     (st_clr_s),
      .we      (st_we_s),
      .wr_q    (qi_idx_s),
      .wr_w    (wi_r),
      .wr_data (st_wdata_s),
      .rd_q    (rd_q),
      .rd_w    (rd_w),
      .rd_data (rd_data)
   );

   assign cpu_rst   = cpu_rst_r;
   assign cpu_SP    = cpu_sp_r;
   assign cpu_EP    = cpu_ep_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign q_ok      = q_ok_r;
   assign q_timeout = q_to_r;

endmodule

// File: doc/path_query_sequencer.md
Name: path_query_sequencer

Overview:
- Batch controller for the t1c_riscv_cpu path planner.
- Feeds up to N_QUERIES (start point, end point) pairs to the CPU one at a time. For each pair it holds the CPU in reset, releases it, then waits for path_found or a timeout.
- Captures the N_PATH_WORDS path words of each query into an internal result store, readable by index.
- Replaces the fixed single-pair SP/EP hookup at the FPGA top level; sits between the top level and the CPU.

Parameters:
- NODE_W, 5, width of one node id (SP/EP).
- N_PATH_WORDS, 9, number of 32-bit path words exported by the CPU.
- N_QUERIES, 4, maximum queries per batch.
- RST_CYC, 4, cycles cpu_rst is held high before each query.
- TIMEOUT_CYC, 1000000, maximum RUN cycles per query (20 ms at 50 MHz).

Ports:
- clk_50M  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that starts a batch.
- num_q  in  $clog2(N_QUERIES+1)  queries in the batch; sampled on start.
- sp_list  in  N_QUERIES*NODE_W  start points; query i occupies bits [i*NODE_W +: NODE_W]; sampled on start.
- ep_list  in  N_QUERIES*NODE_W  end points, same packing; sampled on start.
- cpu_rst  out  1  reset to the CPU.
- cpu_SP  out  NODE_W  start point of the current query.
- cpu_EP  out  NODE_W  end point of the current query.
- cpu_path_found  in  1  path_found from the CPU.
- cpu_path  in  N_PATH_WORDS*32  path0..pathN-1 concatenated, word 0 in the LSBs.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse when a batch ends.
- q_ok  out  N_QUERIES  per-query "path found" flag.
- q_timeout  out  N_QUERIES  per-query "timed out" flag.
- rd_q  in  $clog2(N_QUERIES)  read query index.
- rd_w  in  $clog2(N_PATH_WORDS)  read word index.
- rd_data  out  32  result word at (rd_q, rd_w).

Behaviour:
- Reset values: cpu_rst=1, cpu_SP=0, cpu_EP=0, busy=0, done=0, q_ok=0, q_timeout=0. Result store cleared to 0. State=IDLE.
- Reset asserted mid-batch aborts the batch immediately; the CPU stays held in reset.
- States: IDLE, LOAD, RUN, CAPTURE, NEXT, FINISH.
- IDLE:
  - cpu_rst=1.
  - On start with num_q != 0: latch num_q and the lists, clear q_ok, q_timeout and the store, set qi=0, go to LOAD.
  - num_q > N_QUERIES is clamped to N_QUERIES.
  - start with num_q=0: done pulses the next cycle; busy never rises.
  - start while busy is ignored.
- LOAD:
  - cpu_SP/cpu_EP = entry qi; cpu_rst=1 for exactly RST_CYC cycles.
  - Then cpu_rst falls, the timeout counter clears, go to RUN.
- RUN:
  - cpu_path_found passes through a 2-flop synchroniser; it counts as found only when the synchronised value is high 2 consecutive cycles.
  - Found: go to CAPTURE.
  - Otherwise the timeout counter increments. Reaching TIMEOUT_CYC-1 sets q_timeout[qi]; the store for qi stays 0; go to NEXT.
  - Found and timeout in the same cycle: found wins.
- CAPTURE:
  - Copies one word per cycle: word k of cpu_path goes to store[qi][k], for k=0..N_PATH_WORDS-1. Takes N_PATH_WORDS cycles.
  - cpu_rst stays low so the CPU outputs remain stable.
  - After the last word: set q_ok[qi], go to NEXT.
- NEXT:
  - cpu_rst=1, qi increments.
  - If qi+1 == latched num_q, go to FINISH; else go to LOAD.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. q_ok, q_timeout and the store hold until the next accepted start.
- busy is high from the cycle after start through the FINISH cycle.
- rd_data is registered: 1-cycle latency from rd_q/rd_w. Out-of-range rd_q or rd_w returns 0.
- The store is written only in CAPTURE; reading during a batch is allowed and returns partial results.
- Widths: timeout counter is $clog2(TIMEOUT_CYC) bits and saturates, never wraps. The qi counter has one extra bit so qi == num_q with num_q = N_QUERIES compares correctly.

Decomposition:
- Package path_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, CAPTURE, NEXT, FINISH);
  - default localparams for NODE_W and N_PATH_WORDS;
  - helper function for NODE_W slice extraction.
- One sub-module: path_result_store. N_QUERIES*N_PATH_WORDS x 32 register file with one write port, one registered read port and synchronous clear.

Test Plan:
- Single query: num_q=1, SP=8, EP=17. Model asserts path_found 50 cycles after cpu_rst falls, path0=32'h0008_0911. Required: q_ok=0001, q_timeout=0000, rd(0,0)=32'h0008_0911, done pulses once.
- Batch of 3: model answers queries 0 and 2 and never answers query 1. TIMEOUT_CYC=100 in the bench. Required: q_ok=0101, q_timeout=0010, store for query 1 all 0, cpu_rst high RST_CYC=4 cycles before each query.
- Glitch filter: path_found high for 1 cycle only. Required: no capture, the query ends in timeout.
- start during busy with different lists: ignored. Original results unchanged; exactly one done pulse.
- reset asserted during CAPTURE of word 4: all outputs return to reset values next edge, cpu_rst=1, rd(0,0)=0 afterwards.
- num_q=0 and num_q=7 with N_QUERIES=4: the first gives done one cycle later with busy never high; the second runs exactly 4 queries.
